// File: rtl/multi_bit_sync_filt.sv
// multi_bit_sync_filt
// Multi-channel level synchroniser. Each 1-bit channel goes through a
// NUM_STAGES flop chain into the CLK domain. An optional stability filter
// follows the chain, and each channel gives registered one-cycle RISE/FALL
// pulses. CHANGE is the registered OR of all channel updates.
// Optional feature macro: MULTI_BIT_SYNC_GLITCH_FILTER_EN
//   defined   -> per-channel counters. A new chain value must persist for
//                FILT_CYCLES edges before SYNC accepts it.
//   undefined -> no counters. SYNC follows the chain output every edge, and
//                FILT_CYCLES is ignored.
// Reset is asynchronous assert, active-low. Release is expected to be
// synchronised to CLK outside this block.

module multi_bit_sync_filt #(
    parameter int                NUM_STAGES  = 2,
    parameter int                NUM_CH      = 4,
    parameter int                FILT_CYCLES = 3,
    parameter logic [NUM_CH-1:0] RST_VAL     = '0
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic [NUM_CH-1:0] ASYNC,
    output logic [NUM_CH-1:0] SYNC,
    output logic [NUM_CH-1:0] RISE,
    output logic [NUM_CH-1:0] FALL,
    output logic              CHANGE
);

    // Illegal parameter sets build a dead block with constant outputs
    // instead of malformed chains.
    localparam bit PARAMS_OK = (NUM_STAGES >= 2) && (NUM_CH >= 1) && (FILT_CYCLES >= 1);

    // Per-channel "SYNC accepts the chain output on this edge".
    logic [NUM_CH-1:0] update;

    generate
        if (PARAMS_OK) begin : g_legal
            logic change_reg;

            for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
                logic [NUM_STAGES-1:0] chain_reg;
                logic                  s;
                logic                  sync_reg;
                logic                  rise_reg;
                logic                  fall_reg;

                // Synchroniser chain: stage 0 samples the asynchronous level.
                always_ff @(posedge CLK or negedge RST_n) begin
                    if (!RST_n) begin
                        chain_reg <= {NUM_STAGES{RST_VAL[gi]}};
                    end else begin
                        chain_reg <= {chain_reg[NUM_STAGES-2:0], ASYNC[gi]};
                    end
                end

                assign s = chain_reg[NUM_STAGES-1];

`ifdef MULTI_BIT_SYNC_GLITCH_FILTER_EN
                // The counter clears when it reaches its last value, so it never wraps.
                localparam int              CNT_W    = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
                localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

                logic [CNT_W-1:0] cnt_reg;

                // Count consecutive edges on which the chain output differs
                // from the accepted level. Agreement or acceptance restarts it.
                always_ff @(posedge CLK or negedge RST_n) begin
                    if (!RST_n) begin
                        cnt_reg <= '0;
                    end else if ((s == sync_reg) || update[gi]) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                assign update[gi] = (s != sync_reg) && (cnt_reg == CNT_LAST);
`else
                assign update[gi] = (s != sync_reg);
`endif

                // Accepted level and its edge pulses, all taken on the same edge.
                always_ff @(posedge CLK or negedge RST_n) begin
                    if (!RST_n) begin
                        sync_reg <= RST_VAL[gi];
                        rise_reg <= 1'b0;
                        fall_reg <= 1'b0;
                    end else begin
                        if (update[gi]) begin
                            sync_reg <= s;
                        end
                        rise_reg <= update[gi] & s;
                        fall_reg <= update[gi] & ~s;
                    end
                end

                assign SYNC[gi] = sync_reg;
                assign RISE[gi] = rise_reg;
                assign FALL[gi] = fall_reg;
            end

            // A single CHANGE pulse covers any number of simultaneous channel updates.
            always_ff @(posedge CLK or negedge RST_n) begin
                if (!RST_n) begin
                    change_reg <= 1'b0;
                end else begin
                    change_reg <= |update;
                end
            end

            assign CHANGE = change_reg;
        end else begin : g_illegal
            assign update = '0;
            assign SYNC   = '0;
            assign RISE   = '0;
            assign FALL   = '0;
            assign CHANGE = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_multi_bit_sync_filt.sv
// Testbench for multi_bit_sync_filt. It combines three kinds of stimulus:
// - a table of reset and propagation vectors,
// - hand-written multi-cycle sequences,
// - randomized stimulus.
// A history-based reference model checks every clock edge. The model keeps
// the sampled ASYNC values in a queue. SYNC accepts a new value once the
// last F_EFF chain outputs all disagree with it.

module tb_multi_bit_sync_filt;

    localparam int         NS      = 2;
    localparam int         NCH     = 4;
    localparam int         FC      = 3;
    localparam logic [3:0] RST_VAL = 4'h0;
`ifdef MULTI_BIT_SYNC_GLITCH_FILTER_EN
    localparam int         F_EFF   = FC;
`else
    localparam int         F_EFF   = 1;
`endif
    // Edge offset, from the capturing edge k, at which SYNC and its pulse appear.
    localparam int         LAT     = NS + F_EFF - 1;

    logic           CLK = 1'b0;
    logic           RST_n;
    logic [NCH-1:0] ASYNC;
    logic [NCH-1:0] SYNC;
    logic [NCH-1:0] RISE;
    logic [NCH-1:0] FALL;
    logic           CHANGE;

    int n_checks = 0;
    int n_err    = 0;
    int edge_no  = 0;

    multi_bit_sync_filt #(
        .NUM_STAGES  (NS),
        .NUM_CH      (NCH),
        .FILT_CYCLES (FC),
        .RST_VAL     (RST_VAL)
    ) dut (
        .CLK    (CLK),
        .RST_n  (RST_n),
        .ASYNC  (ASYNC),
        .SYNC   (SYNC),
        .RISE   (RISE),
        .FALL   (FALL),
        .CHANGE (CHANGE)
    );

    always #5 CLK = ~CLK;

    // Reference model state.
    logic [NCH-1:0] hist[$];
    logic [NCH-1:0] m_sync;
    logic [NCH-1:0] m_rise;
    logic [NCH-1:0] m_fall;
    logic           m_change;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, edge_no, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < NS + F_EFF; i++) hist.push_back(RST_VAL);
        m_sync   = RST_VAL;
        m_rise   = '0;
        m_fall   = '0;
        m_change = 1'b0;
    endtask

    task automatic model_edge(input logic [NCH-1:0] a, input logic rn);
        logic [NCH-1:0] upd;
        logic [NCH-1:0] s;
        int n;
        if (!rn) begin
            model_reset();
        end else begin
            hist.push_back(a);
            n = hist.size();
            // Chain output just before this edge is the sample taken NS edges ago.
            s   = hist[n-1-NS];
            upd = '1;
            for (int b = 0; b < F_EFF; b++) begin
                for (int i = 0; i < NCH; i++) begin
                    if (hist[n-1-NS-b][i] == m_sync[i]) upd[i] = 1'b0;
                end
            end
            m_rise   = upd & s;
            m_fall   = upd & ~s;
            m_change = |upd;
            m_sync   = (m_sync & ~upd) | (s & upd);
            if (hist.size() > 64) void'(hist.pop_front());
        end
    endtask

    // One clock transaction: drive away from the edge, clock, compare with the model.
    task automatic step(input logic [NCH-1:0] a, input logic rn);
        @(negedge CLK);
        ASYNC = a;
        RST_n = rn;
        if (!rn) begin
            #1;
            chk("async_rst", {19'b0, SYNC, RISE, FALL, CHANGE}, {19'b0, RST_VAL, 9'b0});
        end
        @(posedge CLK);
        model_edge(a, rn);
        #1;
        chk("model", {19'b0, SYNC, RISE, FALL, CHANGE},
            {19'b0, m_sync, m_rise, m_fall, m_change});
        edge_no++;
        $display("edge %0d rst_n=%b async=%b sync=%b rise=%b fall=%b change=%b",
                 edge_no, rn, a, SYNC, RISE, FALL, CHANGE);
    endtask

    // Apply a settled input change and check old level, then the pulse edge, then quiet.
    task automatic run_change(input string name, input logic [3:0] a, input logic [3:0] old_sync,
                              input logic [3:0] er, input logic [3:0] ef);
        for (int j = 0; j <= LAT + 2; j++) begin
            step(a, 1'b1);
            if (j < LAT)
                chk({name, "_before"}, {19'b0, SYNC, RISE, FALL, CHANGE}, {19'b0, old_sync, 9'b0});
            else if (j == LAT)
                chk({name, "_edge"}, {19'b0, SYNC, RISE, FALL, CHANGE}, {19'b0, a, er, ef, 1'b1});
            else
                chk({name, "_after"}, {19'b0, SYNC, RISE, FALL, CHANGE}, {19'b0, a, 9'b0});
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic       rn;
        logic [3:0] sync;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       change;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic [3:0] ra;
        logic       rrn;

        ASYNC = '0;
        RST_n = 1'b0;
        model_reset();

        // Table: reset with ASYNC=F for 5 edges, then release and watch one rising edge.
        for (int i = 0; i < 20; i++) begin
            tbl[i].a  = 4'hF;
            tbl[i].rn = (i >= 5);
            if (i < 5) begin
                tbl[i].sync = 4'h0; tbl[i].rise = 4'h0; tbl[i].fall = 4'h0; tbl[i].change = 1'b0;
            end else begin
                tbl[i].sync   = ((i - 5) >= LAT) ? 4'hF : 4'h0;
                tbl[i].rise   = ((i - 5) == LAT) ? 4'hF : 4'h0;
                tbl[i].fall   = 4'h0;
                tbl[i].change = ((i - 5) == LAT);
            end
        end
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].a, tbl[i].rn);
            chk("table", {19'b0, SYNC, RISE, FALL, CHANGE},
                {19'b0, tbl[i].sync, tbl[i].rise, tbl[i].fall, tbl[i].change});
        end

        // Single-channel falls, then a simultaneous rise and fall on two channels.
        run_change("ch1_fall",  4'b1101, 4'b1111, 4'b0000, 4'b0010);
        run_change("ch2_fall",  4'b1001, 4'b1101, 4'b0000, 4'b0100);
        run_change("ch2r_ch3f", 4'b0101, 4'b1001, 4'b0100, 4'b1000);
        run_change("ch0_fall",  4'b0100, 4'b0101, 4'b0000, 4'b0001);

`ifdef MULTI_BIT_SYNC_GLITCH_FILTER_EN
        // A 2-cycle high pulse on channel 0 is shorter than the filter window.
        for (int j = 0; j < 10; j++) begin
            step((j < 2) ? 4'b0101 : 4'b0100, 1'b1);
            chk("glitch_reject", {29'b0, SYNC[0], RISE[0], CHANGE}, 32'd0);
        end
`else
        // Without the filter a 1-cycle glitch shows up as a RISE and then a FALL.
        for (int j = 0; j < 6; j++) begin
            step((j == 0) ? 4'b0101 : 4'b0100, 1'b1);
            if (j == 2)
                chk("glitch_rise", {19'b0, SYNC, RISE, FALL, CHANGE}, {19'b0, 4'b0101, 4'b0001, 4'b0000, 1'b1});
            if (j == 3)
                chk("glitch_fall", {19'b0, SYNC, RISE, FALL, CHANGE}, {19'b0, 4'b0100, 4'b0000, 4'b0001, 1'b1});
        end
`endif

        // Reset lands while channel 0 is partway through its count.
        for (int j = 0; j < LAT; j++) begin
            step(4'b0101, 1'b1);
            chk("pre_rst_quiet", {19'b0, SYNC, RISE, FALL, CHANGE}, {19'b0, 4'b0100, 9'b0});
        end
        step(4'b0101, 1'b0);
        step(4'b0101, 1'b0);
        run_change("post_rst", 4'b0101, 4'b0000, 4'b0101, 4'b0000);

        // Randomized traffic with occasional resets, checked by the model.
        for (int i = 0; i < 300; i++) begin
            ra  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : ASYNC;
            rrn = ($urandom_range(0, 99) != 0);
            step(ra, rrn);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Watchdog. It should never trigger, because every loop above is bounded.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
